periph_uart: RTL and testbench

Memory-mapped 8N1 UART peripheral occupying the 0xF000–0xFFFF I/O window that the CPU's load/store path diverts away from the SPI memory controller. It accepts single-cycle register read/write strobes from the core, buffers outgoing bytes in a small TX FIFO, serialises them on `tx_out`, and deserialises `rx_in` into a one-byte holding register with status flags. All registers are 8 bits wide, matching the core's data path.

---
 rtl/periph_uart.sv | 170 +++++++++++++++++
 tb/tb_periph_uart.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/periph_uart.sv
// periph_uart: memory-mapped 8N1 UART with a TX FIFO and 1-cycle register access.
// The receiver is compiled in only when PERIPH_UART_RX_EN is defined.
module periph_uart #(
    parameter int          TX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd103
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic [15:0] addr_in,
    input  logic        req_in,
    input  logic        we_in,
    input  logic [7:0]  wdata_in,
    output logic [7:0]  rdata_out,
    output logic        ack_out,
    output logic        tx_out,
    input  logic        rx_in
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_SEND} tx_state_t;
    tx_state_t tx_state;
    logic [7:0] fifo [TX_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [15:0] div, tx_div, tx_cnt;
    logic [8:0] tx_shift;
    logic [3:0] tx_n;
    logic tx_ovf, rx_valid, rx_ovr, rx_ferr;
    logic [7:0] rx_data, status, rd_mux;
    logic data_wr, data_rd, stat_rd, fifo_empty, fifo_full, tx_empty, pop, push;
    logic unused;

    assign data_wr = req_in && we_in && addr_in[3:0] == 4'h0;
    assign data_rd = req_in && !we_in && addr_in[3:0] == 4'h0;
    assign stat_rd = req_in && !we_in && addr_in[3:0] == 4'h1;
    assign fifo_empty = wr_ptr == rd_ptr;
    assign fifo_full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign tx_empty = fifo_empty && tx_state == T_IDLE;
    // a pop in the same cycle frees a slot, so a write while full still lands
    assign pop = tx_state == T_IDLE && !fifo_empty;
    assign push = data_wr && (!fifo_full || pop);
    assign status = {2'b00, tx_ovf, rx_ferr, rx_ovr, rx_valid, fifo_full, tx_empty};

    always_comb
        rd_mux = addr_in[3:0] == 4'h0 ? rx_data :
                 addr_in[3:0] == 4'h1 ? status :
                 addr_in[3:0] == 4'h2 ? div[7:0] :
                 addr_in[3:0] == 4'h3 ? div[15:8] : 8'h00;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            ack_out <= 1'b0;
            rdata_out <= 8'h00;
            wr_ptr <= '0;
            div <= DIV_RESET;
            tx_ovf <= 1'b0;
        end else begin
            ack_out <= req_in;
            rdata_out <= req_in ? rd_mux : 8'h00;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (req_in && we_in && addr_in[3:0] == 4'h2) div[7:0] <= wdata_in;
            if (req_in && we_in && addr_in[3:0] == 4'h3) div[15:8] <= wdata_in;
            tx_ovf <= (data_wr && fifo_full && !pop) || (tx_ovf && !stat_rd);
        end
    end

    always_ff @(posedge clk_in)
        if (push) fifo[wr_ptr[AW-1:0]] <= wdata_in;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            tx_state <= T_IDLE;
            tx_out <= 1'b1;
            rd_ptr <= '0;
            tx_shift <= '1;
            tx_cnt <= '0;
            tx_div <= '0;
            tx_n <= '0;
        end else begin
            case (tx_state)
                T_IDLE: if (!fifo_empty) begin
                    tx_shift <= {1'b1, fifo[rd_ptr[AW-1:0]]};
                    rd_ptr <= rd_ptr + PTR_ONE;
                    tx_state <= T_LOAD;
                end
                T_LOAD: begin
                    tx_out <= 1'b0;
                    tx_cnt <= '0;
                    tx_div <= div;
                    tx_n <= '0;
                    tx_state <= T_SEND;
                end
                T_SEND: if (tx_cnt == tx_div) begin
                    tx_cnt <= '0;
                    tx_div <= div;
                    if (tx_n == 4'd9) tx_state <= T_IDLE;
                    else begin
                        tx_out <= tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[8:1]};
                        tx_n <= tx_n + 4'd1;
                    end
                end else tx_cnt <= tx_cnt + 16'd1;
                default: tx_state <= T_IDLE;
            endcase
        end
    end

`ifdef PERIPH_UART_RX_EN
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    rx_state_t rx_state;
    logic [2:0] rx_sync;
    logic [15:0] rx_div, rx_cnt;
    logic [7:0] rx_shift;
    logic [2:0] rx_n;
    logic rx_s, rx_fall, rx_done;

    // rx_sync[1] is the synchronised line, rx_sync[2] its previous value
    assign rx_s = rx_sync[1];
    assign rx_fall = rx_sync[2] && !rx_sync[1];
    assign rx_done = rx_state == R_STOP && rx_cnt == rx_div;
    assign unused = ^{addr_in[15:4]};

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rx_sync <= '1;
            rx_state <= R_IDLE;
            rx_div <= '0;
            rx_cnt <= '0;
            rx_shift <= '0;
            rx_n <= '0;
            rx_data <= 8'h00;
            rx_valid <= 1'b0;
            rx_ovr <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[1:0], rx_in};
            rx_valid <= rx_done || (rx_valid && !data_rd);
            rx_ovr <= (rx_done && rx_valid && !data_rd) || (rx_ovr && !stat_rd);
            rx_ferr <= (rx_done && !rx_s) || (rx_ferr && !stat_rd);
            if (rx_done) rx_data <= rx_shift;
            case (rx_state)
                R_IDLE: if (rx_fall) begin
                    rx_state <= R_START;
                    rx_cnt <= '0;
                    rx_div <= div;
                end
                R_START: if (rx_cnt == {1'b0, rx_div[15:1]}) begin
                    rx_cnt <= '0;
                    rx_n <= '0;
                    rx_state <= rx_s ? R_IDLE : R_DATA;
                end else rx_cnt <= rx_cnt + 16'd1;
                R_DATA: if (rx_cnt == rx_div) begin
                    rx_cnt <= '0;
                    rx_div <= div;
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_n <= rx_n + 3'd1;
                    if (rx_n == 3'd7) rx_state <= R_STOP;
                end else rx_cnt <= rx_cnt + 16'd1;
                R_STOP: if (rx_done) rx_state <= R_IDLE;
                else rx_cnt <= rx_cnt + 16'd1;
            endcase
        end
    end
`else
    assign rx_data = 8'h00;
    assign rx_valid = 1'b0;
    assign rx_ovr = 1'b0;
    assign rx_ferr = 1'b0;
    assign unused = ^{addr_in[15:4], rx_in, data_rd};
`endif
endmodule

// File: tb/tb_periph_uart.sv
// tb_periph_uart: directed register vectors plus TX/RX frame sequences at DIV_RESET=3.
module tb_periph_uart;
    logic clk_in = 1'b0;
    logic reset_n_in = 1'b0;
    logic [15:0] addr_in = '0;
    logic req_in = 1'b0;
    logic we_in = 1'b0;
    logic [7:0] wdata_in = '0;
    logic [7:0] rdata_out;
    logic ack_out;
    logic tx_out;
    logic rx_in = 1'b1;

    int checks = 0;
    int passes = 0;
    int frame_err = 0;
    logic [7:0] tx_q [$];

    periph_uart #(.TX_DEPTH(4), .DIV_RESET(16'd3)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .addr_in(addr_in), .req_in(req_in),
        .we_in(we_in), .wdata_in(wdata_in), .rdata_out(rdata_out), .ack_out(ack_out),
        .tx_out(tx_out), .rx_in(rx_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic ak);
        req_in = 1'b1; we_in = w; addr_in = a; wdata_in = d;
        @(negedge clk_in);
        rd = rdata_out; ak = ack_out;
        req_in = 1'b0; we_in = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] rd; logic ak;
        access(1'b0, a, 8'h00, rd, ak);
        check(name, {23'd0, ak, rd}, {23'd0, 1'b1, exp});
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] rd; logic ak;
        access(1'b1, a, d, rd, ak);
        check("write_ack", 32'(ak), 32'd1);
    endtask

    task automatic wait_q(input int n);
        int budget = 600;
        while (tx_q.size() < n && budget > 0) begin
            @(negedge clk_in);
            budget--;
        end
        check("tx_frames_seen", tx_q.size(), n);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        repeat (8) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (8) @(negedge clk_in);
        end
        rx_in = stop;
        repeat (8) @(negedge clk_in);
        rx_in = 1'b1;
    endtask

    // decodes frames on tx_out at 4 clocks per bit, sampling mid-bit
    initial forever begin
        @(negedge clk_in);
        if (reset_n_in && !tx_out) begin
            logic [7:0] b;
            logic ok;
            repeat (2) @(negedge clk_in);
            ok = !tx_out;
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk_in);
                b[i] = tx_out;
            end
            repeat (4) @(negedge clk_in);
            ok = ok && tx_out;
            tx_q.push_back(b);
            if (!ok) frame_err++;
        end
    end

    initial begin
        logic [7:0] rd, frame;
        logic ak, ok, exp_bit;
        vecs[0]  = '{1'b0, 16'hF001, 8'h00, 8'h01};
        vecs[1]  = '{1'b0, 16'hF002, 8'h00, 8'h03};
        vecs[2]  = '{1'b0, 16'hF003, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 16'hF002, 8'h5A, 8'h00};
        vecs[4]  = '{1'b0, 16'hF002, 8'h00, 8'h5A};
        vecs[5]  = '{1'b1, 16'hF013, 8'h12, 8'h00};
        vecs[6]  = '{1'b0, 16'hFFF3, 8'h00, 8'h12};
        vecs[7]  = '{1'b0, 16'hF0A2, 8'h00, 8'h5A};
        vecs[8]  = '{1'b1, 16'hF005, 8'hFF, 8'h00};
        vecs[9]  = '{1'b0, 16'hF005, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 16'hF00F, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 16'hF000, 8'h00, 8'h00};
        vecs[12] = '{1'b1, 16'hF002, 8'h03, 8'h00};
        vecs[13] = '{1'b1, 16'hF003, 8'h00, 8'h00};
        vecs[14] = '{1'b0, 16'hF002, 8'h00, 8'h03};
        vecs[15] = '{1'b0, 16'hF001, 8'h00, 8'h01};

        repeat (3) @(negedge clk_in);
        check("reset_outputs", {22'd0, tx_out, ack_out, rdata_out}, {22'd0, 1'b1, 1'b0, 8'h00});
        reset_n_in = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i < 16; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, ak);
            if (vecs[i].we) check($sformatf("vec%0d_ack", i), 32'(ak), 32'd1);
            else check($sformatf("vec%0d_read", i), {23'd0, ak, rd}, {23'd0, 1'b1, vecs[i].exp});
        end

        // single byte: start bit exactly two edges after the write, 4 clocks per bit
        wr(16'hF000, 8'hA5);
        @(negedge clk_in);
        check("ack_single_pulse", 32'(ack_out), 32'd0);
        check("tx_before_start", 32'(tx_out), 32'd1);
        @(negedge clk_in);
        frame = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            exp_bit = i == 0 ? 1'b0 : i == 9 ? 1'b1 : frame[i-1];
            ok = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (tx_out !== exp_bit) ok = 1'b0;
                @(negedge clk_in);
            end
            check($sformatf("a5_bit%0d", i), 32'(ok), 32'd1);
        end
        rd_chk("status_after_a5", 16'hF001, 8'h01);
        check("a5_monitor", tx_q.size() == 1 ? 32'(tx_q[0]) : 32'hFFFF, 32'hA5);
        tx_q.delete();

        // six back-to-back writes: one enters the shifter, four fill the FIFO, the last drops
        for (int i = 1; i <= 6; i++) wr(16'hF000, 8'(i * 8'h11));
        rd_chk("status_ovf_set", 16'hF001, 8'h22);
        rd_chk("status_ovf_clear", 16'hF001, 8'h02);
        wait_q(5);
        for (int i = 0; i < 5; i++)
            check($sformatf("fifo_byte%0d", i), i < tx_q.size() ? 32'(tx_q[i]) : 32'hFFFF, 32'((i + 1) * 8'h11));
        repeat (6) @(negedge clk_in);
        check("tx_frame_errors", frame_err, 0);
        check("tx_frame_count", tx_q.size(), 5);
        rd_chk("status_fifo_drained", 16'hF001, 8'h01);
        tx_q.delete();

        wr(16'hF002, 8'h07);
`ifdef PERIPH_UART_RX_EN
        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge clk_in);
        rd_chk("rx_status_valid", 16'hF001, 8'h05);
        rd_chk("rx_data_3c", 16'hF000, 8'h3C);
        rd_chk("rx_status_cleared", 16'hF001, 8'h01);
        send_rx(8'h81, 1'b1);
        send_rx(8'h7E, 1'b0);
        repeat (4) @(negedge clk_in);
        rd_chk("rx_status_ovr_ferr", 16'hF001, 8'h1D);
        rd_chk("rx_status_sticky_clr", 16'hF001, 8'h05);
        rd_chk("rx_data_second", 16'hF000, 8'h7E);
        rd_chk("rx_status_final", 16'hF001, 8'h01);
`else
        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge clk_in);
        rd_chk("norx_status", 16'hF001, 8'h01);
        rd_chk("norx_data", 16'hF000, 8'h00);
`endif

        // reset in the middle of a frame
        wr(16'hF000, 8'h5A);
        repeat (12) @(negedge clk_in);
        #2 reset_n_in = 1'b0;
        #1 check("reset_async", {22'd0, tx_out, ack_out, rdata_out}, {22'd0, 1'b1, 1'b0, 8'h00});
        repeat (2) @(negedge clk_in);
        reset_n_in = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_in);
            if (tx_out !== 1'b1) ok = 1'b0;
        end
        check("frame_abandoned", 32'(ok), 32'd1);
        rd_chk("status_after_reset", 16'hF001, 8'h01);
        rd_chk("div_lo_after_reset", 16'hF002, 8'h03);
        rd_chk("div_hi_after_reset", 16'hF003, 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
